// File: rtl/lut_layer_pipe_if.sv
// Handshake, data and table-programming bundle for lut_layer_pipe.
// LUT_CFG_READBACK_EN adds the table readback signals.
interface lut_layer_pipe_if #(
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 1,
    parameter int NUM_NEURONS = 16,
    parameter int NIDX_W      = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
    logic                            cfg_we;
    logic [NIDX_W-1:0]               cfg_neuron;
    logic [IN_BITS-1:0]              cfg_addr;
    logic [OUT_BITS-1:0]             cfg_wdata;
`ifdef LUT_CFG_READBACK_EN
    logic                            cfg_re;
    logic                            cfg_rvalid;
    logic [OUT_BITS-1:0]             cfg_rdata;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_wdata, cfg_re,
        input  in_ready, out_valid, out_data, cfg_rvalid, cfg_rdata
    );
    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_wdata, cfg_re,
        output in_ready, out_valid, out_data, cfg_rvalid, cfg_rdata
    );
`else
    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/lut_layer_pipe.sv
// Two-stage pipelined layer of runtime-programmable LUT neurons with valid/ready on both sides.
// Optional table readback port is enabled by LUT_CFG_READBACK_EN.
module lut_layer_pipe #(
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 1,
    parameter int NUM_NEURONS = 16,
    parameter int NIDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    lut_layer_pipe_if.slave   bus
);
    localparam int DEPTH = 2 ** IN_BITS;

    logic                           v1_r;
    logic                           v2_r;
    logic [NUM_NEURONS*IN_BITS-1:0] d1_r;
    logic                           adv1_s;
    logic                           adv2_s;
    logic                           lu_en_s;

    assign adv2_s       = ~v2_r | bus.out_ready;
    assign adv1_s       = ~v1_r | adv2_s;
    assign lu_en_s      = v1_r & adv2_s;
    assign bus.in_ready = adv1_s;
    assign bus.out_valid = v2_r;

    // Stage valids and the S1 address register; S2 valid follows S1 whenever S2 advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            d1_r <= '0;
        end else begin
            if (adv1_s) begin
                v1_r <= bus.in_valid;
                if (bus.in_valid) begin
                    d1_r <= bus.in_data;
                end
            end
            if (adv2_s) begin
                v2_r <= v1_r;
            end
        end
    end

`ifdef LUT_CFG_READBACK_EN
    logic [NUM_NEURONS*OUT_BITS-1:0] rd_all_s;
    logic [NUM_NEURONS-1:0]          rd_hit_s;
    logic [OUT_BITS-1:0]             rd_sel_s;
    logic                            cfg_rvalid_r;
    logic [OUT_BITS-1:0]             cfg_rdata_r;
`endif

    genvar n;
    generate
        for (n = 0; n < NUM_NEURONS; n++) begin : g_neuron
            // An index that never matches keeps out-of-range writes from touching any table.
            localparam logic [NIDX_W-1:0] NID = NIDX_W'(n);

            logic [OUT_BITS-1:0] tbl_r [DEPTH];
            logic [OUT_BITS-1:0] act_r;
            logic                wr_en_s;

            assign wr_en_s = bus.cfg_we & (bus.cfg_neuron == NID);

            // Truth table storage; writes land at the edge regardless of pipeline state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int a = 0; a < DEPTH; a++) begin
                        tbl_r[a] <= '0;
                    end
                end else if (wr_en_s) begin
                    tbl_r[bus.cfg_addr] <= bus.cfg_wdata;
                end
            end

            // S2 lookup reads the table before any same-edge write takes effect.
            always_ff @(posedge clk) begin
                if (rst) begin
                    act_r <= '0;
                end else if (lu_en_s) begin
                    act_r <= tbl_r[d1_r[n*IN_BITS +: IN_BITS]];
                end
            end

            assign bus.out_data[n*OUT_BITS +: OUT_BITS] = act_r;

`ifdef LUT_CFG_READBACK_EN
            assign rd_all_s[n*OUT_BITS +: OUT_BITS] = tbl_r[bus.cfg_addr];
            assign rd_hit_s[n]                      = (bus.cfg_neuron == NID);
`endif
        end
    endgenerate

`ifdef LUT_CFG_READBACK_EN
    // One-hot select across neurons; no hit (out-of-range index) yields zero.
    always_comb begin
        rd_sel_s = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            rd_sel_s = rd_sel_s | (rd_all_s[k*OUT_BITS +: OUT_BITS] & {OUT_BITS{rd_hit_s[k]}});
        end
    end

    // Registered readback response, one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rvalid_r <= 1'b0;
            cfg_rdata_r  <= '0;
        end else begin
            cfg_rvalid_r <= bus.cfg_re;
            if (bus.cfg_re) begin
                cfg_rdata_r <= rd_sel_s;
            end
        end
    end

    assign bus.cfg_rvalid = cfg_rvalid_r;
    assign bus.cfg_rdata  = cfg_rdata_r;
`endif

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Scoreboard bench for lut_layer_pipe: directed vectors, expected results queued at input
// acceptance and popped by an independent output monitor.
module tb_lut_layer_pipe;
    localparam int IB = 6;
    localparam int OB = 1;
    localparam int NN = 16;
    localparam int NW = 5;
    localparam int DW = NN * IB;
    localparam int OW = NN * OB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_layer_pipe_if #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN), .NIDX_W(NW)) bus ();

    lut_layer_pipe #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN), .NIDX_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [OB-1:0] mdl [NN][64];
    logic [OW-1:0] exp_q [$];
    int checks = 0;
    int fails  = 0;
    int n_out  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic f3(input logic [5:0] a);
        return (a[1] & a[0]) | (a[5] & (a[1] | a[0]));
    endfunction

    function automatic logic [DW-1:0] mk(input int nsel, input logic [5:0] a, input logic [5:0] other);
        logic [DW-1:0] r;
        for (int i = 0; i < NN; i++) r[i*IB +: IB] = (i == nsel) ? a : other;
        return r;
    endfunction

    function automatic logic [OW-1:0] model_out(input logic [DW-1:0] d);
        logic [OW-1:0] r;
        for (int i = 0; i < NN; i++) r[i*OB +: OB] = mdl[i][d[i*IB +: IB]];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NN; i++)
            for (int a = 0; a < 64; a++) mdl[i][a] = '0;
    endtask

    // Offer one vector; expectation is queued at the edge it is accepted.
    task automatic send(input logic [DW-1:0] d);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (ok) exp_q.push_back(model_out(d));
        else begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int nsel, input int a, input logic [OB-1:0] v);
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = NW'(nsel);
        bus.cfg_addr   = IB'(a);
        bus.cfg_wdata  = v;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        if (nsel < NN) mdl[nsel][a] = v;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output: got %0h with empty scoreboard", bus.out_data);
            end else begin
                check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [OW-1:0] held;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_neuron = '0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
`ifdef LUT_CFG_READBACK_EN
        bus.cfg_re     = 1'b0;
`endif
        model_clear();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
`ifdef LUT_CFG_READBACK_EN
        check("rst_cfg_rvalid", 64'(bus.cfg_rvalid), 64'd0);
        check("rst_cfg_rdata", 64'(bus.cfg_rdata), 64'd0);
`endif

        // 1: unwritten tables, two-cycle latency
        send(mk(0, 6'b101100, 6'b101100));
        check("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // 2: neuron 3 programmed with f, all 64 addresses back-to-back
        for (int a = 0; a < 64; a++) cfg_write(3, a, f3(6'(a)));
        base = n_out;
        for (int a = 0; a < 64; a++) send(mk(3, 6'(a), 6'd0));
        drain();
        check("stream64_count", 64'(n_out - base), 64'd64);

        // Out-of-range neuron index must not alias onto neuron 0
        cfg_write(16, 7, 1'b1);
        send(mk(0, 6'd7, 6'd0));
        drain();

        // 3: 10-vector stream with a 5-cycle downstream stall
        base = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) send(mk(3, 6'(i * 7 + 3), 6'(i)));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                held = bus.out_data;
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                repeat (4) begin
                    @(negedge clk);
                    check("stall_hold", 64'(bus.out_data), 64'(held));
                end
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 64'(n_out - base), 64'd10);

        // 4: write collides with S2 lookup of the same entry
        send(mk(0, 6'd5, 6'd0));
        cfg_write(0, 5, 1'b1);
        send(mk(0, 6'd5, 6'd0));
        drain();

        // 5: reset with two vectors in flight
        bus.out_ready = 1'b0;
        send(mk(3, 6'd3, 6'd0));
        send(mk(3, 6'd35, 6'd0));
        rst = 1'b1;
        exp_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_flight_valid", 64'(bus.out_valid), 64'd0);
        check("rst_flight_ready", 64'(bus.in_ready), 64'd1);
        base = n_out;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_flight_none", 64'(n_out - base), 64'd0);
        send(mk(3, 6'd3, 6'd0));
        send(mk(3, 6'd63, 6'd5));
        send(mk(0, 6'd5, 6'd0));
        drain();

`ifdef LUT_CFG_READBACK_EN
        // Tables cleared by reset, visible through readback
        bus.cfg_re = 1'b1; bus.cfg_neuron = NW'(0); bus.cfg_addr = 6'd5;
        @(posedge clk); #1;
        bus.cfg_re = 1'b0;
        check("rb_after_rst", 64'(bus.cfg_rdata), 64'd0);

        // 6: readback timing, out-of-range and same-cycle write
        cfg_write(15, 63, 1'b1);
        bus.cfg_re = 1'b1; bus.cfg_neuron = NW'(15); bus.cfg_addr = 6'd63;
        @(posedge clk); #1;
        bus.cfg_re = 1'b0;
        check("rb_valid", 64'(bus.cfg_rvalid), 64'd1);
        check("rb_data", 64'(bus.cfg_rdata), 64'd1);
        bus.cfg_re = 1'b1; bus.cfg_neuron = NW'(16); bus.cfg_addr = 6'd63;
        @(posedge clk); #1;
        bus.cfg_re = 1'b0;
        check("rb_oor", 64'(bus.cfg_rdata), 64'd0);
        @(posedge clk); #1;
        check("rb_valid_drop", 64'(bus.cfg_rvalid), 64'd0);
        bus.cfg_re = 1'b1; bus.cfg_we = 1'b1; bus.cfg_neuron = NW'(15);
        bus.cfg_addr = 6'd63; bus.cfg_wdata = 1'b0;
        @(posedge clk); #1;
        bus.cfg_re = 1'b0; bus.cfg_we = 1'b0;
        mdl[15][63] = 1'b0;
        check("rb_collide_old", 64'(bus.cfg_rdata), 64'd1);
        bus.cfg_re = 1'b1;
        @(posedge clk); #1;
        bus.cfg_re = 1'b0;
        check("rb_collide_new", 64'(bus.cfg_rdata), 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
